// File: rtl/dataout_serializer.sv
// rtl/dataout_serializer.sv - canonicalise an (x, y) pair mod 2^255-19 and stream it as W-bit words
// Captures two reducer beats, then emits 2*(256/W) words LSW first, x before y.
module dataout_serializer #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_red_valid,
  input  logic [254:0] i_red_data,
  output logic         o_red_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic         o_out_last,
  input  logic         i_out_ready
);

  localparam int N  = 256 / W;
  localparam int NW = 2 * N;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [254:0] Q = {255{1'b1}} - 255'd18;

  generate
    if (!(W == 32 || W == 64 || W == 128 || W == 256)) begin : g_bad_width
      $error("dataout_serializer: W must be 32, 64, 128 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_WAIT_X = 2'd0,
    S_WAIT_Y = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [254:0]  r_x;
  logic [254:0]  r_y;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_data;
  logic [254:0]  w_canon;
  logic [511:0]  w_pair;
  logic [CW:0]   w_next_idx;
  logic          w_is_last;
  logic          w_red_hs;
  logic          w_out_hs;

  // Input is below 2^255 < 2Q, so a single conditional subtract is enough.
  assign w_canon    = (i_red_data >= Q) ? (i_red_data - Q) : i_red_data;
  assign w_pair     = {1'b0, r_y, 1'b0, r_x};
  assign w_is_last  = (r_cnt == CW'(NW - 1));
  assign w_next_idx = (CW + 1)'(r_cnt) + (CW + 1)'(1);
  assign w_red_hs   = i_red_valid && o_red_ready;
  assign w_out_hs   = o_out_valid && i_out_ready;
  assign o_out_data = r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_WAIT_X;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_red_ready = 1'b0;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    case (r_state)
      S_WAIT_X: begin
        o_red_ready = 1'b1;
        if (i_red_valid) w_next = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        o_red_ready = 1'b1;
        if (i_red_valid) w_next = S_SEND;
      end
      S_SEND: begin
        o_out_valid = 1'b1;
        o_out_last  = w_is_last;
        if (i_out_ready && w_is_last) w_next = S_WAIT_X;
      end
      default: begin
        w_next = S_WAIT_X;
      end
    endcase
  end

  // The output word register is preloaded with the next word on each accept,
  // so o_out_data never depends combinationally on i_out_ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        S_WAIT_X: begin
          if (w_red_hs) r_x <= w_canon;
        end
        S_WAIT_Y: begin
          if (w_red_hs) begin
            r_y    <= w_canon;
            r_cnt  <= '0;
            r_data <= w_pair[W-1:0];
          end
        end
        S_SEND: begin
          if (w_out_hs) begin
            if (w_is_last) begin
              r_data <= '0;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_data <= w_pair[w_next_idx * W +: W];
            end
          end
        end
        default: begin
          r_data <= '0;
        end
      endcase
    end
  end

endmodule
